// File: rtl/ofm_drain.sv
// Drains the OFM byte memory after a layer: reads bytes in order, packs them
// little-endian into 32-bit words and offers each word on a valid/ready port.
module ofm_drain #(
    parameter int OFM_AW  = 8,
    parameter int WORD_AW = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [OFM_AW:0]    count,
    output logic               ofmRdEn,
    output logic [OFM_AW-1:0]  ofmRdAddr,
    input  logic [7:0]         ofmRdData,
    output logic               outValid,
    input  logic               outReady,
    output logic [31:0]        outData,
    output logic [WORD_AW-1:0] outAddr,
    output logic               busy,
    output logic               done
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_CAP,
        ST_SEND,
        ST_DONE
    } state_t;

    state_t          state;
    logic [OFM_AW:0] cnt;
    logic [OFM_AW:0] idx;
    logic [OFM_AW:0] idx_inc;

    // idx is one bit wider than the address so a full-depth count is reachable
    assign idx_inc = idx + 1'b1;

    // outData doubles as the packing register; its lane is the low two bits of idx
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            idx       <= '0;
            ofmRdEn   <= 1'b0;
            ofmRdAddr <= '0;
            outValid  <= 1'b0;
            outData   <= '0;
            outAddr   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (count != '0) begin
                            cnt       <= count;
                            idx       <= '0;
                            outData   <= '0;
                            outAddr   <= '0;
                            ofmRdEn   <= 1'b1;
                            ofmRdAddr <= '0;
                            state     <= ST_RD;
                        end else begin
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end
                    end
                end
                ST_RD: begin
                    ofmRdEn <= 1'b0;
                    state   <= ST_CAP;
                end
                ST_CAP: begin
                    outData[{idx[1:0], 3'b000} +: 8] <= ofmRdData;
                    idx <= idx_inc;
                    if (idx[1:0] == 2'd3 || idx_inc == cnt) begin
                        outValid <= 1'b1;
                        state    <= ST_SEND;
                    end else begin
                        ofmRdEn   <= 1'b1;
                        ofmRdAddr <= idx_inc[OFM_AW-1:0];
                        state     <= ST_RD;
                    end
                end
                ST_SEND: begin
                    if (outReady) begin
                        outValid <= 1'b0;
                        outData  <= '0;
                        outAddr  <= outAddr + 1'b1;
                        if (idx == cnt) begin
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            ofmRdEn   <= 1'b1;
                            ofmRdAddr <= idx[OFM_AW-1:0];
                            state     <= ST_RD;
                        end
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ofm_drain.sv
// Scoreboard bench for ofm_drain: expected words are queued with the stimulus
// and a negedge monitor pops and compares on every output handshake.
module tb_ofm_drain;

    localparam int OFM_AW  = 8;
    localparam int WORD_AW = 6;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [OFM_AW:0]    count;
    logic               ofmRdEn;
    logic [OFM_AW-1:0]  ofmRdAddr;
    logic [7:0]         ofmRdData = '0;
    logic               outValid;
    logic               outReady;
    logic [31:0]        outData;
    logic [WORD_AW-1:0] outAddr;
    logic               busy;
    logic               done;

    logic [7:0]         ofm [0:255];
    logic [7:0]         max_addr = '0;
    logic [37:0]        sbq [$];
    int                 errors = 0;
    int                 checks = 0;
    int                 hs_count = 0;
    bit                 rand_ready = 1'b0;

    ofm_drain #(.OFM_AW(OFM_AW), .WORD_AW(WORD_AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .count     (count),
        .ofmRdEn   (ofmRdEn),
        .ofmRdAddr (ofmRdAddr),
        .ofmRdData (ofmRdData),
        .outValid  (outValid),
        .outReady  (outReady),
        .outData   (outData),
        .outAddr   (outAddr),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // synchronous-read OFM model
    always @(posedge clk) begin
        if (ofmRdEn) begin
            ofmRdData <= ofm[ofmRdAddr];
            if (ofmRdAddr > max_addr) max_addr <= ofmRdAddr;
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_ready) outReady = 1'($urandom_range(0, 1));
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: pops on handshake, checks hold-stability while stalled
    initial begin
        logic               pv;
        logic [31:0]        pd;
        logic [WORD_AW-1:0] pa;
        logic [37:0]        e;
        pv = 1'b0;
        pd = '0;
        pa = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                pv = 1'b0;
            end else begin
                if (pv) begin
                    chk("hold_valid", outValid, 1);
                    chk("hold_data", outData, pd);
                    chk("hold_addr", outAddr, pa);
                end
                if (outValid && outReady) begin
                    hs_count++;
                    if (sbq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_unexpected: got word %0h at %0d expected none", outData, outAddr);
                    end else begin
                        e = sbq.pop_front();
                        chk("word_data", outData, e[31:0]);
                        chk("word_addr", outAddr, e[37:32]);
                    end
                    pv = 1'b0;
                end else begin
                    pv = outValid;
                    pd = outData;
                    pa = outAddr;
                end
            end
        end
    end

    task automatic run_drain(input string tag, input int c, input int exp_done,
                             input int exp_hs, input int exp_fv, input int stall,
                             input int inj);
        int hs0;
        int fv;
        bit seen;
        hs0  = hs_count;
        fv   = -1;
        seen = 1'b0;
        @(posedge clk); #1;
        if (stall > 0) outReady = 1'b0;
        start = 1'b1;
        count = c[OFM_AW:0];
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 1; cyc <= 4000; cyc++) begin
            if (cyc == 1) chk({tag, "_busy_rise"}, busy, 1);
            if (cyc == inj) begin
                start = 1'b1;
                count = 9'd4;
            end
            if (cyc == inj + 1) start = 1'b0;
            if (outValid && fv < 0) fv = cyc;
            if (stall > 0 && fv >= 0 && cyc < fv + stall) chk({tag, "_stall_valid"}, outValid, 1);
            if (stall > 0 && fv >= 0 && cyc == fv + stall) outReady = 1'b1;
            if (done) begin
                seen = 1'b1;
                if (exp_done >= 0) chk({tag, "_done_cycle"}, cyc, exp_done);
                break;
            end
            @(posedge clk); #1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_done_timeout: got no done expected done", tag);
        end
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, done, 0);
        chk({tag, "_busy_fall"}, busy, 0);
        chk({tag, "_valid_rise"}, fv, exp_fv);
        chk({tag, "_handshakes"}, hs_count - hs0, exp_hs);
        chk({tag, "_sb_empty"}, sbq.size(), 0);
    endtask

    initial begin
        rst      = 1'b0;
        start    = 1'b0;
        count    = '0;
        outReady = 1'b1;
        for (int k = 0; k < 256; k++) ofm[k] = (k < 8) ? 8'(8'h10 + k) : 8'(k);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", {ofmRdEn, ofmRdAddr, outValid, outData, outAddr, busy, done}, '0);
        rst = 1'b1;

        sbq.push_back({6'd0, 32'h13121110});
        sbq.push_back({6'd1, 32'h17161514});
        run_drain("full", 8, 19, 2, 9, 0, 0);

        sbq.push_back({6'd0, 32'h13121110});
        sbq.push_back({6'd1, 32'h00001514});
        run_drain("partial", 6, 15, 2, 9, 0, 0);

        sbq.push_back({6'd0, 32'h13121110});
        run_drain("backpressure", 4, 15, 1, 9, 5, 0);

        run_drain("zero", 0, 1, 0, -1, 0, 0);

        sbq.push_back({6'd0, 32'h13121110});
        sbq.push_back({6'd1, 32'h17161514});
        run_drain("start_busy", 8, 19, 2, 9, 0, 3);

        // reset during byte 2 of a count=8 drain
        @(posedge clk); #1;
        start = 1'b1;
        count = 9'd8;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        chk("rst_pre_busy", busy, 1);
        rst = 1'b0;
        #1;
        chk("rst_outputs", {ofmRdEn, ofmRdAddr, outValid, outData, outAddr, busy, done}, '0);
        repeat (3) begin
            @(posedge clk); #1;
            chk("rst_no_done", done, 0);
        end
        rst = 1'b1;
        sbq.push_back({6'd0, 32'h13121110});
        run_drain("restart", 4, 10, 1, 9, 0, 0);

        for (int k = 0; k < 256; k++) ofm[k] = 8'(k);
        for (int n = 0; n < 64; n++) begin
            logic [7:0] b0;
            b0 = 8'(4 * n);
            sbq.push_back({6'(n), b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0});
        end
        rand_ready = 1'b1;
        run_drain("full_depth", 256, -1, 64, 9, 0, 0);
        rand_ready = 1'b0;
        chk("max_rd_addr", max_addr, 255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
